// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V style core.
// Contents:
//   - default XLEN / INST_W widths and the sequential PC step
//   - major opcode constants consumed by the Control decoder
//   - ifu_state_t, the instruction fetch unit state encoding
package riscv_pkg;

  localparam int XLEN_DEF    = 64;
  localparam int INST_W_DEF  = 64;
  localparam int PC_STEP_DEF = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;

  // ERR is only reachable when the fetch watchdog is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/inst_fetch_unit_pc_reg.sv
// pc_reg: program counter register with next-PC priority select.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (pc -> RESET_PC)
//   advance_i        update the PC this edge (instruction retired)
//   load_i/target_i  same-cycle redirect, highest priority
//   pend_valid_i/pend_target_i  earlier redirect captured while waiting
//   pc_o             current PC
//   pc_plus_o        pc + PC_STEP, wrapping modulo 2^XLEN
module pc_reg #(
  parameter int               XLEN     = 64,
  parameter int               PC_STEP  = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            pend_valid_i,
  input  logic [XLEN-1:0] pend_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  assign pc_plus_o = pc_q + XLEN'(PC_STEP);
  assign pc_o      = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      if (load_i)            pc_d = target_i;
      else if (pend_valid_i) pc_d = pend_target_i;
      else                   pc_d = pc_plus_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multicycle instruction fetch front end.
// Holds the PC, issues one instruction-memory read at a time, latches the
// returned word into the IR and offers it to Control with valid/ready.
//
// Handshakes:
//   imem: imem_req stays high in FETCH until a cycle with imem_rvalid=1;
//         that edge captures imem_rdata. rvalid is ignored outside FETCH.
//   inst: inst_valid (HOLD) & inst_ready on an edge consumes the IR; the
//         next request is visible the following cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/imem_addr   read request and address (= pc)
//   imem_rvalid/rdata    read response
//   inst/inst_valid      IR contents and valid flag, to Control
//   inst_ready           current instruction finished
//   pc/pc_plus           PC of IR word and pc + PC_STEP
//   pc_load/pc_target    redirect request and target
//   fetch_err            sticky fetch timeout flag
//   dbg_state_o          current FSM state (ifu_state_t encoding)
//
// Build option: define IFU_TIMEOUT_EN to add the FETCH watchdog (ERR state,
// fetch_err). Without it FETCH waits indefinitely and fetch_err is 0.
module inst_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN           = XLEN_DEF,
  parameter int              INST_W         = INST_W_DEF,
  parameter int              PC_STEP        = PC_STEP_DEF,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus,
  input  logic              pc_load,
  input  logic [XLEN-1:0]   pc_target,
  output logic              fetch_err,
  output logic [1:0]        dbg_state_o
);

  ifu_state_t        state_q, state_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic              pend_valid_q, pend_valid_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic              advance;

  pc_reg #(
    .XLEN     (XLEN),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance_i     (advance),
    .load_i        (pc_load),
    .target_i      (pc_target),
    .pend_valid_i  (pend_valid_q),
    .pend_target_i (pend_q),
    .pc_o          (pc),
    .pc_plus_o     (pc_plus)
  );

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc;
  assign inst_valid  = (state_q == HOLD);
  assign inst        = ir_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    advance      = 1'b0;
`ifdef IFU_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
`ifdef IFU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      FETCH: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          state_d = HOLD;
        end
`ifdef IFU_TIMEOUT_EN
        // Counter holds the number of elapsed FETCH cycles without data;
        // the edge that would make it reach the limit enters ERR.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (inst_ready) begin
          // pc_reg applies the redirect priority: same-cycle load, then
          // pending target, then sequential step.
          advance      = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = FETCH;
`ifdef IFU_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else if (pc_load) begin
          pend_valid_d = 1'b1;
          pend_d       = pc_target;
        end
      end
      default: begin
`ifdef IFU_TIMEOUT_EN
        state_d = ERR;
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

`ifdef IFU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed testbench for inst_fetch_unit. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at the same point.
module tb_inst_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;
  logic [63:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] pc;
  logic [63:0] pc_plus;
  logic        pc_load;
  logic [63:0] pc_target;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_unit #(
    .XLEN           (64),
    .INST_W         (64),
    .PC_STEP        (4),
    .RESET_PC       (64'h0),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .pc          (pc),
    .pc_plus     (pc_plus),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .fetch_err   (fetch_err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one-cycle memory response
  task automatic respond(input logic [63:0] data);
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 64'h0;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 64'h0;
    inst_ready  = 1'b0;
    pc_load     = 1'b0;
    pc_target   = 64'h0;

    // reset state
    #3;
    chk("rst_req", {63'b0, imem_req}, 64'h0);
    chk("rst_valid", {63'b0, inst_valid}, 64'h0);
    chk("rst_inst", inst, 64'h0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_pc_plus", pc_plus, 64'h4);
    chk("rst_err", {63'b0, fetch_err}, 64'h0);
    chk("rst_state", {62'b0, dbg_state}, {62'b0, IDLE});
    #5 rst_n = 1'b1;

    // 1: zero-wait fetch
    step();
    chk("t1_req", {63'b0, imem_req}, 64'h1);
    chk("t1_addr", imem_addr, 64'h0);
    respond(64'h00500093);
    chk("t1_inst", inst, 64'h00500093);
    chk("t1_valid", {63'b0, inst_valid}, 64'h1);
    chk("t1_req_low", {63'b0, imem_req}, 64'h0);

    // rvalid in HOLD must not disturb IR
    imem_rvalid = 1'b1; imem_rdata = 64'hDEAD;
    step();
    imem_rvalid = 1'b0;
    chk("hold_ir_stable", inst, 64'h00500093);

    // 2: 3-cycle latency, ready held high
    inst_ready = 1'b1;
    step();
    chk("t2_addr4", imem_addr, 64'h4);
    chk("t2_valid_low", {63'b0, inst_valid}, 64'h0);
    step(); step();
    chk("t2_req_held", {63'b0, imem_req}, 64'h1);
    respond(64'h11);
    chk("t2_inst1", inst, 64'h11);
    chk("t2_pc_plus8", pc_plus, 64'h8);
    step();
    chk("t2_addr8", imem_addr, 64'h8);
    step(); step();
    chk("t2_req_held2", {63'b0, imem_req}, 64'h1);
    inst_ready = 1'b0;
    respond(64'h22);
    chk("t2_pc8", pc, 64'h8);
    chk("t2_pc_plusC", pc_plus, 64'hC);

    // 3: pending redirect captured while not ready
    pc_load = 1'b1; pc_target = 64'h100;
    step();
    pc_load = 1'b0; pc_target = 64'h0;
    step();
    chk("t3_hold_pc", pc, 64'h8);
    chk("t3_hold_valid", {63'b0, inst_valid}, 64'h1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t3_addr100", imem_addr, 64'h100);

    // pc_load ignored in FETCH
    pc_load = 1'b1; pc_target = 64'h500;
    step();
    pc_load = 1'b0;
    respond(64'h33);
    chk("t3_pc100", pc, 64'h100);

    // 4a: latest pending loses to a same-cycle load
    pc_load = 1'b1; pc_target = 64'h100; step();
    pc_target = 64'h200; step();
    pc_load = 1'b0; step();
    inst_ready = 1'b1; pc_load = 1'b1; pc_target = 64'h300;
    step();
    inst_ready = 1'b0; pc_load = 1'b0;
    chk("t4_addr300", imem_addr, 64'h300);
    respond(64'h44);

    // 4b: latest pending wins without same-cycle load
    pc_load = 1'b1; pc_target = 64'h100; step();
    pc_target = 64'h200; step();
    pc_load = 1'b0; step();
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t4_addr200", imem_addr, 64'h200);
    respond(64'h55);
    // pending must have been cleared by the handshake
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t4_addr204", imem_addr, 64'h204);
    respond(64'h66);

    // wrap-around at the top of the address space (misaligned target too)
    inst_ready = 1'b1; pc_load = 1'b1; pc_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    inst_ready = 1'b0; pc_load = 1'b0;
    chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    respond(64'h77);
    chk("wrap_pc_plus", pc_plus, 64'h0);
    inst_ready = 1'b1; pc_load = 1'b1; pc_target = 64'h103;
    step();
    pc_load = 1'b0;
    chk("misaligned_addr", imem_addr, 64'h103);
    respond(64'h88);

    // 5: reset during a FETCH wait at pc=0x40
    pc_load = 1'b1; pc_target = 64'h40;
    step();
    inst_ready = 1'b0; pc_load = 1'b0;
    chk("t5_addr40", imem_addr, 64'h40);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_drop", {63'b0, imem_req}, 64'h0);
    chk("t5_pc_reset", pc, 64'h0);
    #2 rst_n = 1'b1;
    step();
    chk("t5_restart_req", {63'b0, imem_req}, 64'h1);
    chk("t5_restart_addr", imem_addr, 64'h0);

    // 6: no response
`ifdef IFU_TIMEOUT_EN
    repeat (7) step();
    chk("t6_req_before", {63'b0, imem_req}, 64'h1);
    step();
    chk("t6_req_err", {63'b0, imem_req}, 64'h0);
    chk("t6_err", {63'b0, fetch_err}, 64'h1);
    chk("t6_state", {62'b0, dbg_state}, {62'b0, ERR});
    repeat (5) step();
    chk("t6_err_sticky", {63'b0, fetch_err}, 64'h1);
    chk("t6_valid", {63'b0, inst_valid}, 64'h0);
`else
    repeat (1000) step();
    chk("t6_req_wait", {63'b0, imem_req}, 64'h1);
    chk("t6_err", {63'b0, fetch_err}, 64'h0);
    chk("t6_state", {62'b0, dbg_state}, {62'b0, FETCH});
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
